// File: rtl/csr_pkg.sv
// csr_pkg
// Shared definitions for the machine-mode CSR/trap unit: CSR addresses,
// access-operation encodings, mstatus bit positions, write masks and the
// interrupt cause codes used by the arbiter.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MSTATUS_WMASK       = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_MASK    = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK           = 32'h0000_0888;
    localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

endpackage

// File: rtl/csr_counter.sv
// csr_counter
// CNT_W-bit free-running counter exposed as two XLEN halves.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   inc_i, inhibit_i    count request and freeze control
//   wr_lo_i, wr_hi_i    software write strobes for the low/high half
//   wdata_i             software write data
//   lo_o, hi_o          current low/high halves (hi_o is 0 if CNT_W <= XLEN)
module csr_counter #(
    parameter int CNT_W = 64,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            inhibit_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] hi_o
);

    // The counter is viewed through a 2*XLEN window so both halves can be
    // sliced uniformly regardless of CNT_W.
    localparam int EXT_W = 2 * XLEN;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EXT_W-1:0] cur_ext, wr_ext;

    assign cur_ext = EXT_W'(cnt_q);
    assign lo_o    = cur_ext[XLEN-1:0];
    assign hi_o    = cur_ext[EXT_W-1:XLEN];

    // A software write replaces only its own half and suppresses the
    // increment for that cycle, so no carry reaches the other half.
    always_comb begin
        wr_ext = cur_ext;
        if (wr_lo_i) wr_ext[XLEN-1:0] = wdata_i;
        if (wr_hi_i) wr_ext[EXT_W-1:XLEN] = wdata_i;
        if (wr_lo_i || wr_hi_i) begin
            cnt_d = CNT_W'(wr_ext);
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit
// Machine-mode CSR file with trap entry/MRET handling and interrupt
// arbitration. Read in EXE (combinational, with forwarding from the WB
// write), written in WB.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   raddr_i/rdata_o/rillegal_o   EXE read port
//   we_i/op_i/waddr_i/wsrc_i     WB read-modify-write port, willegal_o flag
//   instret_incr_i               instruction retired
//   trap_i/trap_cause_i/_epc_i/_tval_i   trap entry
//   mret_i                       MRET retiring
//   meip_i/mtip_i/msip_i         interrupt lines
//   trap_pc_o/mepc_o             handler and return targets
//   irq_req_o/irq_cause_o        arbitrated interrupt request
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          CNT_W       = 64,
    parameter int unsigned HART_ID     = 0,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [11:0]     raddr_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            rillegal_o,
    input  logic            we_i,
    input  logic [1:0]      op_i,
    input  logic [11:0]     waddr_i,
    input  logic [XLEN-1:0] wsrc_i,
    output logic            willegal_o,
    input  logic            instret_incr_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            meip_i,
    input  logic            mtip_i,
    input  logic            msip_i,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o
);

    localparam bit              HAS_HI      = (CNT_W > XLEN);
    localparam int              CODE_W      = XLEN - 1;
    localparam logic [XLEN-1:0] MTVEC_WMASK = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mcountinhibit_q, mcountinhibit_d;
    logic [XLEN-1:0] mip_q, mip_d;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
    logic [XLEN:0]   wr_view, rd_view;
    logic [XLEN-1:0] wr_old, wr_new_raw, wr_val;
    logic            wr_req, wr_attempt, wr_eff;
    logic [XLEN-1:0] pend, trap_base;
    logic [CODE_W-1:0] irq_code;
    logic            irq_any;

    always_comb begin
        mstatus_rd                   = XLEN'(MSTATUS_MPP_MASK);
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    end

    // Register view of one CSR address; MSB of the result flags an
    // unimplemented address.
    function automatic logic [XLEN:0] csr_read(input logic [11:0] addr);
        logic [XLEN-1:0] d;
        logic            ill;
        d   = '0;
        ill = 1'b0;
        case (addr)
            CSR_MSTATUS:                 d = mstatus_rd;
            CSR_MIE:                     d = mie_q;
            CSR_MTVEC:                   d = mtvec_q;
            CSR_MCOUNTINHIBIT:           d = mcountinhibit_q;
            CSR_MSCRATCH:                d = mscratch_q;
            CSR_MEPC:                    d = mepc_q;
            CSR_MCAUSE:                  d = mcause_q;
            CSR_MTVAL:                   d = mtval_q;
            CSR_MIP:                     d = mip_q;
            CSR_MCYCLE, CSR_CYCLE:       d = mcycle_lo;
            CSR_MINSTRET, CSR_INSTRET:   d = minstret_lo;
            CSR_MCYCLEH, CSR_CYCLEH: begin
                if (HAS_HI) d = mcycle_hi;
                else        ill = 1'b1;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                if (HAS_HI) d = minstret_hi;
                else        ill = 1'b1;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: d = '0;
            CSR_MHARTID:                 d = XLEN'(HART_ID);
            default:                     ill = 1'b1;
        endcase
        return {ill, d};
    endfunction

    // WB read-modify-write. RS/RC with a zero source are pure reads, so they
    // never trip the read-only check. wr_val is the post-mask value the
    // register will hold, which is also what a same-cycle read sees.
    always_comb begin
        wr_view    = csr_read(waddr_i);
        wr_old     = wr_view[XLEN-1:0];
        wr_req     = we_i && (op_i != CSR_OP_NONE);
        wr_attempt = (op_i == CSR_OP_RW) || (wsrc_i != '0);
        willegal_o = wr_req && (wr_view[XLEN] || ((waddr_i[11:10] == 2'b11) && wr_attempt));
        wr_eff     = wr_req && wr_attempt && !willegal_o && !trap_i;

        case (csr_op_e'(op_i))
            CSR_OP_RW: wr_new_raw = wsrc_i;
            CSR_OP_RS: wr_new_raw = wr_old | wsrc_i;
            CSR_OP_RC: wr_new_raw = wr_old & ~wsrc_i;
            default:   wr_new_raw = wr_old;
        endcase

        case (waddr_i)
            CSR_MSTATUS:       wr_val = (wr_new_raw & XLEN'(MSTATUS_WMASK)) | XLEN'(MSTATUS_MPP_MASK);
            CSR_MIE:           wr_val = wr_new_raw & XLEN'(MIE_WMASK);
            CSR_MTVEC:         wr_val = wr_new_raw & MTVEC_WMASK;
            CSR_MEPC:          wr_val = wr_new_raw & ~XLEN'(3);
            CSR_MCOUNTINHIBIT: wr_val = wr_new_raw & XLEN'(MCOUNTINHIBIT_WMASK);
            CSR_MIP:           wr_val = mip_q;
            default:           wr_val = wr_new_raw;
        endcase

        rd_view    = csr_read(raddr_i);
        rillegal_o = rd_view[XLEN];
        rdata_o    = (wr_eff && (raddr_i == waddr_i)) ? wr_val : rd_view[XLEN-1:0];
    end

    csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_mcycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (1'b1),
        .inhibit_i (mcountinhibit_q[0]),
        .wr_lo_i   (wr_eff && (waddr_i == CSR_MCYCLE)),
        .wr_hi_i   (wr_eff && HAS_HI && (waddr_i == CSR_MCYCLEH)),
        .wdata_i   (wr_val),
        .lo_o      (mcycle_lo),
        .hi_o      (mcycle_hi)
    );

    csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_minstret (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (instret_incr_i),
        .inhibit_i (mcountinhibit_q[2]),
        .wr_lo_i   (wr_eff && (waddr_i == CSR_MINSTRET)),
        .wr_hi_i   (wr_eff && HAS_HI && (waddr_i == CSR_MINSTRETH)),
        .wdata_i   (wr_val),
        .lo_o      (minstret_lo),
        .hi_o      (minstret_hi)
    );

    // Next state: software write first, then trap/MRET override. A trap has
    // already squashed the write through wr_eff, and wins over MRET.
    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mcountinhibit_d = mcountinhibit_q;

        if (wr_eff) begin
            case (waddr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wr_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:           mie_d           = wr_val;
                CSR_MTVEC:         mtvec_d         = wr_val;
                CSR_MCOUNTINHIBIT: mcountinhibit_d = wr_val;
                CSR_MSCRATCH:      mscratch_d      = wr_val;
                CSR_MEPC:          mepc_d          = wr_val;
                CSR_MCAUSE:        mcause_d        = wr_val;
                CSR_MTVAL:         mtval_d         = wr_val;
                default: ;
            endcase
        end

        if (trap_i) begin
            mepc_d         = trap_epc_i & ~XLEN'(3);
            mcause_d       = trap_cause_i;
            mtval_d        = trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        mip_d          = '0;
        mip_d[IRQ_MEI] = meip_i;
        mip_d[IRQ_MTI] = mtip_i;
        mip_d[IRQ_MSI] = msip_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
            mip_q           <= '0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mcountinhibit_q <= mcountinhibit_d;
            mip_q           <= mip_d;
        end
    end

    // Vectored mode only applies to interrupt causes; exceptions always go
    // to the base.
    always_comb begin
        trap_base = {mtvec_q[XLEN-1:2], 2'b00};
        trap_pc_o = trap_base;
        if (VECTORED_EN && mtvec_q[0] && trap_cause_i[XLEN-1]) begin
            trap_pc_o = trap_base + {trap_cause_i[XLEN-3:0], 2'b00};
        end
    end

    // Fixed priority MEI > MSI > MTI.
    always_comb begin
        pend     = mip_q & mie_q;
        irq_any  = |pend;
        irq_code = '0;
        if (pend[IRQ_MEI])      irq_code = CODE_W'(IRQ_MEI);
        else if (pend[IRQ_MSI]) irq_code = CODE_W'(IRQ_MSI);
        else if (pend[IRQ_MTI]) irq_code = CODE_W'(IRQ_MTI);
    end

    assign irq_req_o   = mstatus_mie_q & irq_any;
    assign irq_cause_o = irq_any ? {1'b1, irq_code} : '0;
    assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit
// Directed bench for csr_trap_unit. Stimulus drives one cycle at a time and
// queues the expected value of a chosen output for that cycle; a monitor
// running on the falling edge pops and compares.
module tb_csr_trap_unit;

    localparam int SEL_RDATA  = 0;
    localparam int SEL_RILL   = 1;
    localparam int SEL_WILL   = 2;
    localparam int SEL_TRAPPC = 3;
    localparam int SEL_MEPC   = 4;
    localparam int SEL_IRQ    = 5;
    localparam int SEL_CAUSE  = 6;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [11:0] raddr_i;
    logic [31:0] rdata_o;
    logic        rillegal_o;
    logic        we_i;
    logic [1:0]  op_i;
    logic [11:0] waddr_i;
    logic [31:0] wsrc_i;
    logic        willegal_o;
    logic        instret_incr_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_epc_i;
    logic [31:0] trap_tval_i;
    logic        mret_i;
    logic        meip_i, mtip_i, msip_i;
    logic [31:0] trap_pc_o;
    logic [31:0] mepc_o;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    csr_trap_unit #(
        .XLEN(32), .CNT_W(64), .HART_ID(3), .VECTORED_EN(1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .rillegal_o     (rillegal_o),
        .we_i           (we_i),
        .op_i           (op_i),
        .waddr_i        (waddr_i),
        .wsrc_i         (wsrc_i),
        .willegal_o     (willegal_o),
        .instret_incr_i (instret_incr_i),
        .trap_i         (trap_i),
        .trap_cause_i   (trap_cause_i),
        .trap_epc_i     (trap_epc_i),
        .trap_tval_i    (trap_tval_i),
        .mret_i         (mret_i),
        .meip_i         (meip_i),
        .mtip_i         (mtip_i),
        .msip_i         (msip_i),
        .trap_pc_o      (trap_pc_o),
        .mepc_o         (mepc_o),
        .irq_req_o      (irq_req_o),
        .irq_cause_o    (irq_cause_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pickOutput(input int sel);
        case (sel)
            SEL_RDATA:  return rdata_o;
            SEL_RILL:   return {31'b0, rillegal_o};
            SEL_WILL:   return {31'b0, willegal_o};
            SEL_TRAPPC: return trap_pc_o;
            SEL_MEPC:   return mepc_o;
            SEL_IRQ:    return {31'b0, irq_req_o};
            default:    return irq_cause_o;
        endcase
    endfunction

    // Monitor: compare every queued expectation scheduled for this cycle.
    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            int          c;
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            string       n;
            c = cyc_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = pickOutput(s);
            checks++;
            if (c != cyc) begin
                errors++;
                $display("[TB] FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", n, c, cyc);
            end else if (a !== e) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
            end
        end
    end

    task automatic checkOutput(input int sel, input logic [31:0] expv, input string name);
        cyc_q.push_back(cyc);
        sel_q.push_back(sel);
        exp_q.push_back(expv);
        name_q.push_back(name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sets the per-cycle port fields and clears all single-cycle pulses.
    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] waddr,
                                 input logic [31:0] wsrc, input logic [11:0] raddr);
        we_i           = (op != 2'b00);
        op_i           = op;
        waddr_i        = waddr;
        wsrc_i         = wsrc;
        raddr_i        = raddr;
        trap_i         = 1'b0;
        mret_i         = 1'b0;
        instret_incr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i = 1'b1;
        trap_cause_i = '0; trap_epc_i = '0; trap_tval_i = '0;
        meip_i = 1'b0; mtip_i = 1'b0; msip_i = 1'b0;
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h000);
        step();
        step();
        rst_i = 1'b0;

        // Reset state
        trap_cause_i = 32'h8000_0007;
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h300);
        checkOutput(SEL_RDATA, 32'h1800, "rst_mstatus");
        checkOutput(SEL_RILL, 32'h0, "rst_mstatus_rill");
        checkOutput(SEL_IRQ, 32'h0, "rst_irq_req");
        checkOutput(SEL_CAUSE, 32'h0, "rst_irq_cause");
        checkOutput(SEL_MEPC, 32'h0, "rst_mepc");
        checkOutput(SEL_TRAPPC, 32'h0, "rst_trap_pc");
        step();
        trap_cause_i = '0;
        applyStimulus(2'b00, 12'h000, 32'h0, 12'hF14);
        checkOutput(SEL_RDATA, 32'h3, "mhartid");
        checkOutput(SEL_RILL, 32'h0, "mhartid_rill");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h7FF);
        checkOutput(SEL_RDATA, 32'h0, "unimpl_rdata");
        checkOutput(SEL_RILL, 32'h1, "unimpl_rill");
        step();

        // mie WARL, RC and forwarding
        applyStimulus(2'b01, 12'h304, 32'hFFFF_FFFF, 12'h304);
        checkOutput(SEL_RDATA, 32'h888, "mie_rw_fwd");
        checkOutput(SEL_WILL, 32'h0, "mie_rw_will");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h304);
        checkOutput(SEL_RDATA, 32'h888, "mie_read");
        step();
        applyStimulus(2'b11, 12'h304, 32'h8, 12'h304);
        checkOutput(SEL_RDATA, 32'h880, "mie_rc_fwd");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h304);
        checkOutput(SEL_RDATA, 32'h880, "mie_rc_read");
        step();

        // Interrupt arbitration
        applyStimulus(2'b10, 12'h300, 32'h8, 12'h300);
        checkOutput(SEL_RDATA, 32'h1808, "mstatus_rs_fwd");
        step();
        applyStimulus(2'b01, 12'h304, 32'h80, 12'h304);
        mtip_i = 1'b1;
        checkOutput(SEL_RDATA, 32'h80, "mie_mti_fwd");
        checkOutput(SEL_IRQ, 32'h0, "irq_before_latency");
        step();
        applyStimulus(2'b10, 12'h304, 32'h800, 12'h344);
        meip_i = 1'b1;
        checkOutput(SEL_RDATA, 32'h80, "mip_mtip");
        checkOutput(SEL_IRQ, 32'h1, "irq_mti_req");
        checkOutput(SEL_CAUSE, 32'h8000_0007, "irq_mti_cause");
        step();
        applyStimulus(2'b01, 12'h304, 32'h88, 12'h344);
        msip_i = 1'b1;
        checkOutput(SEL_RDATA, 32'h880, "mip_meip_mtip");
        checkOutput(SEL_CAUSE, 32'h8000_000B, "irq_mei_cause");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h344);
        meip_i = 1'b0; mtip_i = 1'b0; msip_i = 1'b0;
        checkOutput(SEL_RDATA, 32'h888, "mip_all");
        checkOutput(SEL_CAUSE, 32'h8000_0003, "irq_msi_over_mti");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h344);
        checkOutput(SEL_RDATA, 32'h0, "mip_cleared");
        checkOutput(SEL_IRQ, 32'h0, "irq_cleared");
        checkOutput(SEL_CAUSE, 32'h0, "irq_cause_cleared");
        step();

        // Trap entry, MRET and trap priority
        applyStimulus(2'b01, 12'h305, 32'h101, 12'h305);
        checkOutput(SEL_RDATA, 32'h101, "mtvec_vectored_fwd");
        step();
        applyStimulus(2'b01, 12'h340, 32'h55, 12'h340);
        trap_i = 1'b1;
        trap_cause_i = 32'h8000_0007; trap_epc_i = 32'h1236; trap_tval_i = 32'hBAD;
        checkOutput(SEL_TRAPPC, 32'h11C, "trap_pc_vectored");
        checkOutput(SEL_RDATA, 32'h0, "mscratch_squash_nofwd");
        checkOutput(SEL_WILL, 32'h0, "mscratch_will");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h300);
        trap_cause_i = 32'h2;
        checkOutput(SEL_TRAPPC, 32'h100, "trap_pc_exception");
        checkOutput(SEL_MEPC, 32'h1234, "trap_mepc");
        checkOutput(SEL_RDATA, 32'h1880, "trap_mstatus");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h340);
        checkOutput(SEL_RDATA, 32'h0, "mscratch_unchanged");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h342);
        checkOutput(SEL_RDATA, 32'h8000_0007, "trap_mcause");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h343);
        mret_i = 1'b1;
        checkOutput(SEL_RDATA, 32'hBAD, "trap_mtval");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h300);
        checkOutput(SEL_RDATA, 32'h1888, "mret_mstatus");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h300);
        trap_i = 1'b1; mret_i = 1'b1;
        trap_cause_i = 32'h2; trap_epc_i = 32'h2000; trap_tval_i = 32'h0;
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h300);
        checkOutput(SEL_RDATA, 32'h1880, "trap_mret_mstatus");
        checkOutput(SEL_MEPC, 32'h2000, "trap_mret_mepc");
        step();
        applyStimulus(2'b01, 12'h305, 32'h200, 12'h342);
        checkOutput(SEL_RDATA, 32'h2, "trap_mret_mcause");
        step();
        applyStimulus(2'b01, 12'h341, 32'h1237, 12'h341);
        trap_cause_i = 32'h8000_0007;
        checkOutput(SEL_TRAPPC, 32'h200, "trap_pc_direct");
        checkOutput(SEL_RDATA, 32'h1234, "mepc_mask_fwd");
        step();
        applyStimulus(2'b01, 12'h344, 32'hFFFF, 12'h344);
        checkOutput(SEL_WILL, 32'h0, "mip_write_legal");
        checkOutput(SEL_RDATA, 32'h0, "mip_write_ignored");
        step();

        // Counters
        applyStimulus(2'b01, 12'hB00, 32'hFFFF_FFFF, 12'hB00);
        checkOutput(SEL_RDATA, 32'hFFFF_FFFF, "mcycle_write_fwd");
        step();
        applyStimulus(2'b01, 12'h320, 32'h1, 12'hB00);
        checkOutput(SEL_RDATA, 32'hFFFF_FFFF, "mcycle_written");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'hB00);
        checkOutput(SEL_RDATA, 32'h0, "mcycle_wrapped_lo");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'hB80);
        checkOutput(SEL_RDATA, 32'h1, "mcycleh_carry");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'hB00);
        checkOutput(SEL_RDATA, 32'h0, "mcycle_inhibited");
        step();
        applyStimulus(2'b01, 12'h320, 32'h0, 12'hC80);
        checkOutput(SEL_RDATA, 32'h1, "cycleh_alias");
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 12'h000, 32'h0, 12'hB82);
            instret_incr_i = 1'b1;
            if (i == 0) checkOutput(SEL_RDATA, 32'h0, "minstreth_zero");
            step();
        end
        applyStimulus(2'b00, 12'h000, 32'h0, 12'hC02);
        checkOutput(SEL_RDATA, 32'h3, "instret_count");
        step();

        // Read-only and unimplemented writes
        applyStimulus(2'b01, 12'hC00, 32'h5, 12'hC00);
        checkOutput(SEL_WILL, 32'h1, "cycle_alias_ro");
        step();
        applyStimulus(2'b01, 12'hF11, 32'h1, 12'hF11);
        checkOutput(SEL_WILL, 32'h1, "mvendorid_rw_illegal");
        checkOutput(SEL_RDATA, 32'h0, "mvendorid_nofwd");
        step();
        applyStimulus(2'b10, 12'hF11, 32'h0, 12'hF11);
        checkOutput(SEL_WILL, 32'h0, "mvendorid_rs_zero");
        checkOutput(SEL_RDATA, 32'h0, "mvendorid_unchanged");
        step();
        applyStimulus(2'b01, 12'h7FF, 32'h1, 12'hF14);
        checkOutput(SEL_WILL, 32'h1, "unimpl_write");
        checkOutput(SEL_RDATA, 32'h3, "mhartid_again");
        step();
        applyStimulus(2'b00, 12'h000, 32'h0, 12'h000);

        for (int i = 0; i < 10 && cyc_q.size() > 0; i++) step();
        if (cyc_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations never compared", cyc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
